// File: rtl/fifo_glb_arbiter_if.sv
// fifo_glb_arbiter_if: request/response bundle between the FIFO controllers and the GLB arbiter.
// slave: arbiter side (requests and GLB read data in; GLB port, permits and read data out).
// master: requester/GLB side, the mirror image.
interface fifo_glb_arbiter_if #(
  parameter int NUM_CH = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [NUM_CH-1:0]             ifmap_read_req_matrix_i;
  logic [NUM_CH-1:0][ADDR_W-1:0] ifmap_glb_read_addr_matrix_i;
  logic [NUM_CH-1:0]             ipsum_read_req_matrix_i;
  logic [NUM_CH-1:0][ADDR_W-1:0] ipsum_glb_read_addr_matrix_i;
  logic [NUM_CH-1:0]             opsum_glb_write_req_matrix_i;
  logic [NUM_CH-1:0][ADDR_W-1:0] opsum_glb_write_addr_matrix_i;
  logic [NUM_CH-1:0][3:0]        opsum_glb_write_web_matrix_i;
  logic [NUM_CH-1:0][DATA_W-1:0] opsum_fifo_pop_data_matrix_i;
  logic [DATA_W-1:0]             glb_rdata_i;
  logic                          glb_en_o;
  logic [3:0]                    glb_web_o;
  logic [ADDR_W-1:0]             glb_addr_o;
  logic [DATA_W-1:0]             glb_wdata_o;
  logic [NUM_CH-1:0]             ifmap_permit_push_matrix_o;
  logic [NUM_CH-1:0]             ipsum_permit_push_matrix_o;
  logic [NUM_CH-1:0]             opsum_permit_pop_matrix_o;
  logic [DATA_W-1:0]             ifmap_glb_read_data_o;
  logic [DATA_W-1:0]             ipsum_glb_read_data_o;
  logic                          fifo_glb_busy_o;
  modport slave (
    input  ifmap_read_req_matrix_i, ifmap_glb_read_addr_matrix_i,
           ipsum_read_req_matrix_i, ipsum_glb_read_addr_matrix_i,
           opsum_glb_write_req_matrix_i, opsum_glb_write_addr_matrix_i,
           opsum_glb_write_web_matrix_i, opsum_fifo_pop_data_matrix_i, glb_rdata_i,
    output glb_en_o, glb_web_o, glb_addr_o, glb_wdata_o,
           ifmap_permit_push_matrix_o, ipsum_permit_push_matrix_o, opsum_permit_pop_matrix_o,
           ifmap_glb_read_data_o, ipsum_glb_read_data_o, fifo_glb_busy_o
  );
  modport master (
    output ifmap_read_req_matrix_i, ifmap_glb_read_addr_matrix_i,
           ipsum_read_req_matrix_i, ipsum_glb_read_addr_matrix_i,
           opsum_glb_write_req_matrix_i, opsum_glb_write_addr_matrix_i,
           opsum_glb_write_web_matrix_i, opsum_fifo_pop_data_matrix_i, glb_rdata_i,
    input  glb_en_o, glb_web_o, glb_addr_o, glb_wdata_o,
           ifmap_permit_push_matrix_o, ipsum_permit_push_matrix_o, opsum_permit_pop_matrix_o,
           ifmap_glb_read_data_o, ipsum_glb_read_data_o, fifo_glb_busy_o
  );
endinterface

// File: rtl/fifo_glb_arbiter.sv
// fifo_glb_arbiter: arbitrates ifmap/ipsum reads and opsum writes onto the single-port GLB.
// Ports: clk, rst_n (async active-low), bus (fifo_glb_arbiter_if.slave: requests, GLB port, permits, read data, busy).
// Priority opsum > ipsum > ifmap; round-robin per class; one transaction in flight at a time.
module fifo_glb_arbiter #(
  parameter int NUM_CH = 32,
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int RD_LAT = 1
) (
  input logic clk,
  input logic rst_n,
  fifo_glb_arbiter_if.slave bus
);
  localparam int CW = NUM_CH > 1 ? $clog2(NUM_CH) : 1;
  typedef enum logic [1:0] {IDLE, ACCESS, WAIT, RESP} state_t;
  typedef enum logic [1:0] {C_IFMAP, C_IPSUM, C_OPSUM} cls_t;
  state_t state, next_state;
  cls_t cls, pick_cls;
  logic [CW-1:0] win, ptr_if, ptr_ip, ptr_op, pick_idx, pick_nxt;
  logic [CW:0] rr_if, rr_ip, rr_op;
  logic [ADDR_W-1:0] addr_q, pick_addr;
  logic [3:0] web_q;
  logic [1:0] cnt;
  logic [DATA_W-1:0] if_data_q, ip_data_q;
  logic [NUM_CH-1:0] onehot;
  logic pick, busy, wr, resp_if, resp_ip;
  // {found, index} of the first request at or above ptr, wrapping at NUM_CH
  function automatic logic [CW:0] rr_pick(input logic [NUM_CH-1:0] req, input logic [CW-1:0] ptr);
    logic [CW:0] r;
    int k;
    r = '0;
    for (int i = NUM_CH - 1; i >= 0; i--) begin
      k = int'(ptr) + i;
      k = k >= NUM_CH ? k - NUM_CH : k;
      if (req[CW'(k)]) r = {1'b1, CW'(k)};
    end
    return r;
  endfunction
  always_comb begin
    rr_if = rr_pick(bus.ifmap_read_req_matrix_i, ptr_if);
    rr_ip = rr_pick(bus.ipsum_read_req_matrix_i, ptr_ip);
    rr_op = rr_pick(bus.opsum_glb_write_req_matrix_i, ptr_op);
    pick = rr_op[CW] | rr_ip[CW] | rr_if[CW];
    pick_cls = rr_op[CW] ? C_OPSUM : rr_ip[CW] ? C_IPSUM : C_IFMAP;
    pick_idx = rr_op[CW] ? rr_op[CW-1:0] : rr_ip[CW] ? rr_ip[CW-1:0] : rr_if[CW-1:0];
    pick_nxt = pick_idx == CW'(NUM_CH - 1) ? '0 : pick_idx + 1'b1;
    pick_addr = pick_cls == C_OPSUM ? bus.opsum_glb_write_addr_matrix_i[pick_idx]
              : pick_cls == C_IPSUM ? bus.ipsum_glb_read_addr_matrix_i[pick_idx]
              : bus.ifmap_glb_read_addr_matrix_i[pick_idx];
  end
  always_comb begin
    next_state = state == IDLE   ? (pick ? ACCESS : IDLE)
               : state == ACCESS ? (cls == C_OPSUM ? IDLE : RD_LAT > 1 ? WAIT : RESP)
               : state == WAIT   ? (cnt == 2'd0 ? RESP : WAIT)
               : IDLE;
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      busy <= 1'b0;
      cls <= C_IFMAP;
      win <= '0;
      addr_q <= '0;
      web_q <= '0;
      cnt <= '0;
      ptr_if <= '0;
      ptr_ip <= '0;
      ptr_op <= '0;
      if_data_q <= '0;
      ip_data_q <= '0;
    end else begin
      state <= next_state;
      busy <= next_state != IDLE;
      if (state == IDLE && pick) begin
        cls <= pick_cls;
        win <= pick_idx;
        addr_q <= pick_addr;
        web_q <= bus.opsum_glb_write_web_matrix_i[pick_idx];
        if (pick_cls == C_IFMAP) ptr_if <= pick_nxt;
        if (pick_cls == C_IPSUM) ptr_ip <= pick_nxt;
        if (pick_cls == C_OPSUM) ptr_op <= pick_nxt;
      end
      // WAIT lasts RD_LAT-1 cycles: preload RD_LAT-2 and leave when it reaches zero
      cnt <= state == ACCESS ? 2'(RD_LAT > 1 ? RD_LAT - 2 : 0) : state == WAIT ? cnt - 2'd1 : cnt;
      if (resp_if) if_data_q <= bus.glb_rdata_i;
      if (resp_ip) ip_data_q <= bus.glb_rdata_i;
    end
  end
  assign wr = state == ACCESS && cls == C_OPSUM;
  assign resp_if = state == RESP && cls == C_IFMAP;
  assign resp_ip = state == RESP && cls == C_IPSUM;
  assign onehot = NUM_CH'(1) << win;
  assign bus.glb_en_o = state == ACCESS;
  assign bus.glb_web_o = wr ? web_q : '0;
  assign bus.glb_addr_o = state == ACCESS ? addr_q : '0;
  assign bus.glb_wdata_o = wr ? bus.opsum_fifo_pop_data_matrix_i[win] : '0;
  assign bus.opsum_permit_pop_matrix_o = wr ? onehot : '0;
  assign bus.ifmap_permit_push_matrix_o = resp_if ? onehot : '0;
  assign bus.ipsum_permit_push_matrix_o = resp_ip ? onehot : '0;
  // read data passes straight through in RESP and is held afterwards
  assign bus.ifmap_glb_read_data_o = resp_if ? bus.glb_rdata_i : if_data_q;
  assign bus.ipsum_glb_read_data_o = resp_ip ? bus.glb_rdata_i : ip_data_q;
  assign bus.fifo_glb_busy_o = busy;
endmodule

// File: tb/tb_fifo_glb_arbiter.sv
// tb_fifo_glb_arbiter: two arbiters (RD_LAT 1 and 3) on shared stimulus, checked against a transaction timeline model.
module tb_fifo_glb_arbiter;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;
  logic [31:0] if_req, ip_req, op_req, rdata;
  logic [31:0][31:0] if_addr, ip_addr, op_addr, pop_data;
  logic [31:0][3:0] op_web;
  fifo_glb_arbiter_if #(.NUM_CH(32), .ADDR_W(32), .DATA_W(32)) b1 ();
  fifo_glb_arbiter_if #(.NUM_CH(32), .ADDR_W(32), .DATA_W(32)) b3 ();
  assign b1.ifmap_read_req_matrix_i = if_req;
  assign b1.ifmap_glb_read_addr_matrix_i = if_addr;
  assign b1.ipsum_read_req_matrix_i = ip_req;
  assign b1.ipsum_glb_read_addr_matrix_i = ip_addr;
  assign b1.opsum_glb_write_req_matrix_i = op_req;
  assign b1.opsum_glb_write_addr_matrix_i = op_addr;
  assign b1.opsum_glb_write_web_matrix_i = op_web;
  assign b1.opsum_fifo_pop_data_matrix_i = pop_data;
  assign b1.glb_rdata_i = rdata;
  assign b3.ifmap_read_req_matrix_i = if_req;
  assign b3.ifmap_glb_read_addr_matrix_i = if_addr;
  assign b3.ipsum_read_req_matrix_i = ip_req;
  assign b3.ipsum_glb_read_addr_matrix_i = ip_addr;
  assign b3.opsum_glb_write_req_matrix_i = op_req;
  assign b3.opsum_glb_write_addr_matrix_i = op_addr;
  assign b3.opsum_glb_write_web_matrix_i = op_web;
  assign b3.opsum_fifo_pop_data_matrix_i = pop_data;
  assign b3.glb_rdata_i = rdata;
  fifo_glb_arbiter #(.NUM_CH(32), .ADDR_W(32), .DATA_W(32), .RD_LAT(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(b1.slave));
  fifo_glb_arbiter #(.NUM_CH(32), .ADDR_W(32), .DATA_W(32), .RD_LAT(3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3.slave));

  typedef struct packed {
    logic en;
    logic [3:0] web;
    logic [31:0] addr, wdata, ifp, ipp, opp, ifd, ipd;
    logic busy;
  } out_t;
  typedef struct {
    logic [31:0] op, ip, ifm, e_op, e_ip, e_if;
  } vec_t;

  int total = 0;
  int passed = 0;
  int lat [2] = '{1, 3};
  // model: ph = cycles since the grant was latched (0 = idle), class 0 ifmap / 1 ipsum / 2 opsum
  int ph [2], mc [2], mi [2];
  logic [31:0] ma [2];
  logic [3:0] mw [2];
  int ptr [2][3];
  logic [31:0] hd [2][2];
  out_t snap [2];
  vec_t tbl [12];

  task automatic chk(int d, string n, logic [63:0] a, logic [63:0] e);
    total++;
    if (a === e) passed++;
    else $display("FAIL dut%0d %s: got %0h expected %0h", d, n, a, e);
  endtask

  function automatic out_t live(int d);
    if (d == 0)
      return out_t'{b1.glb_en_o, b1.glb_web_o, b1.glb_addr_o, b1.glb_wdata_o, b1.ifmap_permit_push_matrix_o,
                    b1.ipsum_permit_push_matrix_o, b1.opsum_permit_pop_matrix_o, b1.ifmap_glb_read_data_o,
                    b1.ipsum_glb_read_data_o, b1.fifo_glb_busy_o};
    return out_t'{b3.glb_en_o, b3.glb_web_o, b3.glb_addr_o, b3.glb_wdata_o, b3.ifmap_permit_push_matrix_o,
                  b3.ipsum_permit_push_matrix_o, b3.opsum_permit_pop_matrix_o, b3.ifmap_glb_read_data_o,
                  b3.ipsum_glb_read_data_o, b3.fifo_glb_busy_o};
  endfunction

  function automatic int rr(logic [31:0] req, int p);
    for (int o = 0; o < 32; o++) if (req[(p + o) % 32]) return (p + o) % 32;
    return -1;
  endfunction

  function automatic out_t expect_out(int d);
    out_t e;
    bit w;
    e = '0;
    w = mc[d] == 2;
    e.busy = ph[d] > 0;
    e.ifd = hd[d][0];
    e.ipd = hd[d][1];
    if (ph[d] == 1) begin
      e.en = 1'b1;
      e.addr = ma[d];
      if (w) begin
        e.web = mw[d];
        e.wdata = pop_data[mi[d]];
        e.opp = 32'b1 << mi[d];
      end
    end
    if (!w && ph[d] == lat[d] + 1) begin
      if (mc[d] == 0) begin e.ifp = 32'b1 << mi[d]; e.ifd = rdata; end
      else begin e.ipp = 32'b1 << mi[d]; e.ipd = rdata; end
    end
    return e;
  endfunction

  task automatic mreset(int d);
    ph[d] = 0; mc[d] = 0; mi[d] = 0; ma[d] = '0; mw[d] = '0;
    for (int c = 0; c < 3; c++) ptr[d][c] = 0;
    hd[d][0] = '0; hd[d][1] = '0;
  endtask

  task automatic mstep(int d);
    logic [31:0] rq [3];
    int w;
    rq[0] = if_req; rq[1] = ip_req; rq[2] = op_req;
    if (ph[d] == 0) begin
      for (int c = 2; c >= 0 && ph[d] == 0; c--) begin
        w = rr(rq[c], ptr[d][c]);
        if (w >= 0) begin
          ph[d] = 1; mc[d] = c; mi[d] = w;
          ma[d] = c == 2 ? op_addr[w] : c == 1 ? ip_addr[w] : if_addr[w];
          mw[d] = op_web[w];
          ptr[d][c] = (w + 1) % 32;
        end
      end
    end else if (mc[d] == 2 ? ph[d] == 1 : ph[d] == lat[d] + 1) begin
      if (mc[d] != 2) hd[d][mc[d]] = rdata;
      ph[d] = 0;
    end else ph[d]++;
  endtask

  task automatic cmp_out(int d, out_t a, out_t e);
    chk(d, "en", 64'(a.en), 64'(e.en));
    chk(d, "web", 64'(a.web), 64'(e.web));
    chk(d, "addr", 64'(a.addr), 64'(e.addr));
    chk(d, "wdata", 64'(a.wdata), 64'(e.wdata));
    chk(d, "ifmap_permit", 64'(a.ifp), 64'(e.ifp));
    chk(d, "ipsum_permit", 64'(a.ipp), 64'(e.ipp));
    chk(d, "opsum_permit", 64'(a.opp), 64'(e.opp));
    chk(d, "ifmap_data", 64'(a.ifd), 64'(e.ifd));
    chk(d, "ipsum_data", 64'(a.ipd), 64'(e.ipd));
    chk(d, "busy", 64'(a.busy), 64'(e.busy));
  endtask

  // one clock: snapshot and check at the falling edge, advance the model, return just after the rising edge
  task automatic cyc();
    @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      snap[d] = live(d);
      if (!rst_n) mreset(d);
      cmp_out(d, snap[d], expect_out(d));
      if (rst_n) mstep(d);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic wait_perm(int d, output out_t s);
    bit hit;
    hit = 1'b0;
    for (int i = 0; i < 20 && !hit; i++) begin
      cyc();
      hit = (snap[d].ifp | snap[d].ipp | snap[d].opp) != '0;
    end
    s = snap[d];
    chk(d, "permit_timeout", 64'(hit), 64'd1);
  endtask

  task automatic wait_idle();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 20 && !ok; i++) begin
      cyc();
      ok = !snap[0].busy && !snap[1].busy;
    end
    chk(0, "idle_timeout", 64'(ok), 64'd1);
  endtask

  task automatic clear_req();
    if_req = '0; ip_req = '0; op_req = '0;
  endtask

  task automatic do_reset();
    clear_req();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
  endtask

  initial begin
    out_t s;
    int idx;
    clear_req();
    rdata = '0;
    for (int i = 0; i < 32; i++) begin
      if_addr[i] = 32'h1000 + 32'(i * 4);
      ip_addr[i] = 32'h2000 + 32'(i * 4);
      op_addr[i] = 32'h3000 + 32'(i * 4);
      op_web[i] = 4'(i);
      pop_data[i] = $urandom;
    end
    for (int d = 0; d < 2; d++) mreset(d);
    do_reset();
    // read of ifmap ch0 with RD_LAT=1
    if_addr[0] = 32'h40;
    rdata = 32'hDEADBEEF;
    if_req = 32'h1;
    cyc();
    if_req = '0;
    cyc();
    chk(0, "t1_en", 64'(snap[0].en), 64'd1);
    chk(0, "t1_addr", 64'(snap[0].addr), 64'h40);
    chk(0, "t1_web", 64'(snap[0].web), 64'd0);
    chk(0, "t1_busy1", 64'(snap[0].busy), 64'd1);
    cyc();
    chk(0, "t1_permit", 64'(snap[0].ifp), 64'h1);
    chk(0, "t1_data", 64'(snap[0].ifd), 64'hDEADBEEF);
    chk(0, "t1_busy2", 64'(snap[0].busy), 64'd1);
    cyc();
    chk(0, "t1_busy3", 64'(snap[0].busy), 64'd0);
    wait_idle();
    // arbitration table on the RD_LAT=1 arbiter, pointers carried from one row to the next
    op_addr[5] = 32'h100; op_web[5] = 4'hF; pop_data[5] = 32'h12345678;
    tbl[0]  = '{32'h20, 32'h4, 0, 32'h20, 0, 0};
    tbl[1]  = '{0, 32'h4, 0, 0, 32'h4, 0};
    tbl[2]  = '{0, 0, 32'h1, 0, 0, 32'h1};
    tbl[3]  = '{0, 0, 32'h3, 0, 0, 32'h2};
    tbl[4]  = '{0, 0, 32'h3, 0, 0, 32'h1};
    tbl[5]  = '{32'h401, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h400, 0, 0};
    tbl[6]  = '{32'h1, 0, 0, 32'h1, 0, 0};
    tbl[7]  = '{0, 32'h9, 0, 0, 32'h8, 0};
    tbl[8]  = '{0, 32'h80000000, 32'hFFFFFFFF, 0, 32'h80000000, 0};
    tbl[9]  = '{0, 32'h3, 0, 0, 32'h1, 0};
    tbl[10] = '{0, 0, 32'h80000001, 0, 0, 32'h80000000};
    tbl[11] = '{0, 0, 32'h80000001, 0, 0, 32'h1};
    foreach (tbl[v]) begin
      op_req = tbl[v].op; ip_req = tbl[v].ip; if_req = tbl[v].ifm;
      rdata = $urandom;
      wait_perm(0, s);
      clear_req();
      chk(0, $sformatf("tbl%0d_opsum", v), 64'(s.opp), 64'(tbl[v].e_op));
      chk(0, $sformatf("tbl%0d_ipsum", v), 64'(s.ipp), 64'(tbl[v].e_ip));
      chk(0, $sformatf("tbl%0d_ifmap", v), 64'(s.ifp), 64'(tbl[v].e_if));
      if (tbl[v].e_op != '0) begin
        idx = 0;
        for (int i = 0; i < 32; i++) if (tbl[v].e_op[i]) idx = i;
        chk(0, $sformatf("tbl%0d_web", v), 64'(s.web), 64'(op_web[idx]));
        chk(0, $sformatf("tbl%0d_wdata", v), 64'(s.wdata), 64'(pop_data[idx]));
        chk(0, $sformatf("tbl%0d_waddr", v), 64'(s.addr), 64'(op_addr[idx]));
      end
      wait_idle();
    end
    // all ifmap channels held: strict round-robin 0..31 then wrap to 0
    do_reset();
    if_req = 32'hFFFFFFFF;
    for (int g = 0; g < 33; g++) begin
      rdata = $urandom;
      wait_perm(0, s);
      chk(0, $sformatf("rr_grant%0d", g), 64'(s.ifp), 64'(32'b1 << (g % 32)));
    end
    clear_req();
    wait_idle();
    // RD_LAT=3 read of ipsum ch31 after reset, then the pointer has wrapped to 0
    do_reset();
    rdata = 32'hCAFEF00D;
    ip_req = 32'h80000000;
    cyc();
    ip_req = '0;
    cyc();
    chk(1, "t4_en", 64'(snap[1].en), 64'd1);
    chk(1, "t4_addr", 64'(snap[1].addr), 64'(ip_addr[31]));
    for (int i = 0; i < 2; i++) begin
      cyc();
      chk(1, "t4_wait_en", 64'(snap[1].en), 64'd0);
      chk(1, "t4_wait_permit", 64'(snap[1].ipp), 64'd0);
      chk(1, "t4_wait_busy", 64'(snap[1].busy), 64'd1);
    end
    cyc();
    chk(1, "t4_permit", 64'(snap[1].ipp), 64'h80000000);
    chk(1, "t4_data", 64'(snap[1].ipd), 64'hCAFEF00D);
    wait_idle();
    ip_req = 32'h80000001;
    wait_perm(1, s);
    clear_req();
    chk(1, "t4_wrap", 64'(s.ipp), 64'h1);
    wait_idle();
    // reset during WAIT: no permit, pointer back to 0 so ch1 wins again instead of ch2
    do_reset();
    if_req = 32'h1;
    wait_perm(1, s);
    clear_req();
    chk(1, "t5_pre", 64'(s.ifp), 64'h1);
    wait_idle();
    if_req = 32'h6;
    cyc();
    cyc();
    rst_n = 1'b0;
    #1;
    s = live(1);
    chk(1, "t5_rst_en", 64'(s.en), 64'd0);
    chk(1, "t5_rst_busy", 64'(s.busy), 64'd0);
    chk(1, "t5_rst_permit", 64'(s.ifp | s.ipp | s.opp), 64'd0);
    chk(1, "t5_rst_addr", 64'(s.addr), 64'd0);
    cyc();
    cyc();
    rst_n = 1'b1;
    wait_perm(1, s);
    clear_req();
    chk(1, "t5_regrant", 64'(s.ifp), 64'h2);
    wait_idle();
    // random traffic against the model
    for (int n = 0; n < 800; n++) begin
      if_req = $urandom_range(0, 3) == 0 ? '0 : $urandom & $urandom & $urandom;
      ip_req = $urandom_range(0, 3) == 0 ? '0 : $urandom & $urandom & $urandom;
      op_req = $urandom_range(0, 2) != 0 ? '0 : $urandom & $urandom & $urandom;
      for (int i = 0; i < 32; i++) begin
        if_addr[i] = $urandom; ip_addr[i] = $urandom; op_addr[i] = $urandom;
        op_web[i] = 4'($urandom); pop_data[i] = $urandom;
      end
      rdata = $urandom;
      cyc();
    end
    clear_req();
    wait_idle();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/fifo_glb_arbiter.md
Name: fifo_glb_arbiter

Overview:
- Sits between the per-channel ifmap/ipsum/opsum FIFO controllers and the single-port GLB SRAM.
- Arbitrates up to 3×NUM_CH outstanding GLB read and write requests and drives the GLB port.
- Returns read data to the winning requester with a one-hot permit pulse.
- Asserts a global busy flag while a transaction is in flight.

Parameters:
NUM_CH, 32, requesters per class (ifmap, ipsum, opsum)
ADDR_W, 32, GLB address width
DATA_W, 32, GLB data width
RD_LAT, 1, GLB read latency in cycles after the enable cycle (legal 1..3)

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
ifmap_read_req_matrix_i  in  NUM_CH  ifmap read requests, held until permit
ifmap_glb_read_addr_matrix_i  in  NUM_CH×ADDR_W  ifmap read address per channel
ipsum_read_req_matrix_i  in  NUM_CH  ipsum read requests
ipsum_glb_read_addr_matrix_i  in  NUM_CH×ADDR_W  ipsum read address per channel
opsum_glb_write_req_matrix_i  in  NUM_CH  opsum write requests
opsum_glb_write_addr_matrix_i  in  NUM_CH×ADDR_W  opsum write address
opsum_glb_write_web_matrix_i  in  NUM_CH×4  opsum byte write-enables (active high per byte)
opsum_fifo_pop_data_matrix_i  in  NUM_CH×DATA_W  opsum FIFO head data
glb_rdata_i  in  DATA_W  GLB read data
glb_en_o  out  1  GLB access enable
glb_web_o  out  4  GLB byte write-enables; 0 means read
glb_addr_o  out  ADDR_W  GLB address
glb_wdata_o  out  DATA_W  GLB write data
ifmap_permit_push_matrix_o  out  NUM_CH  one-hot ifmap data-valid pulse
ipsum_permit_push_matrix_o  out  NUM_CH  one-hot ipsum data-valid pulse
opsum_permit_pop_matrix_o  out  NUM_CH  one-hot opsum pop pulse
ifmap_glb_read_data_o  out  DATA_W  read data to ifmap controllers
ipsum_glb_read_data_o  out  DATA_W  read data to ipsum controllers
fifo_glb_busy_o  out  1  transaction in flight

Behaviour:
- Reset (async, rst_n low):
  - State is IDLE.
  - All outputs are 0.
  - The three round-robin pointers are 0.
  - Latched winner and wait counter are 0.
- FSM states: IDLE, ACCESS, WAIT, RESP.
- IDLE:
  - Class priority is fixed: opsum write > ipsum read > ifmap read.
  - Within a class, round-robin search runs from that class's pointer upward, wrapping at NUM_CH.
  - If any request is present, latch class, channel index and address, then go to ACCESS next cycle.
  - With no requests, stay in IDLE and keep busy=0.
- ACCESS (exactly 1 cycle):
  - Drive glb_en_o=1 and glb_addr_o to the latched address.
  - Write:
    - glb_web_o = latched web; glb_wdata_o = opsum_fifo_pop_data_matrix_i[winner], sampled combinationally this cycle.
    - opsum_permit_pop_matrix_o[winner]=1 this cycle.
    - Next state is IDLE.
  - Read:
    - glb_web_o=0.
    - Next state is WAIT if RD_LAT>1, else RESP.
- WAIT: count down RD_LAT-1 cycles with glb_en_o=0, then go to RESP.
- RESP (1 cycle):
  - Route glb_rdata_i to the class data output; the other class data output holds its last value.
  - Pulse permit_push[winner] of that class.
  - Next state is IDLE.
- Latency: read permit arrives RD_LAT+1 cycles after the grant-latch edge; write permit coincides with the GLB write.
- Throughput: max one transaction per 2 cycles (write) or RD_LAT+2 cycles (read).
- Busy: fifo_glb_busy_o=1 in ACCESS, WAIT and RESP; it is registered from next-state, so it is high in the first cycle after latch.
- Pointer update: on latch, the winning class pointer becomes (winner+1) mod NUM_CH; other pointers are unchanged.
- Request withdrawal:
  - A request dropped after latch is still completed and still receives its permit.
  - Requests arriving during busy wait until IDLE.
- Permit pulses are at most one bit high across all three permit matrices in any cycle.
- Simultaneous requests from all classes: opsum always wins. Starvation of reads is accepted; the L2 controller bounds opsum traffic.
- Reset asserted mid-transaction: immediate return to IDLE with no permit issued; requesters re-request after reset.
- The address/web of non-winning channels is ignored.

Test Plan:
1. Reset then ifmap_read_req=0x1, addr[0]=0x40, glb_rdata=0xDEADBEEF, RD_LAT=1 -> glb_en=1/addr=0x40/web=0 one cycle after latch; next cycle ifmap_permit_push=0x1 and ifmap_glb_read_data=0xDEADBEEF; busy high exactly 2 cycles.
2. opsum req ch5 (addr 0x100, web 0xF, data 0x12345678) concurrent with ipsum req ch2 -> opsum granted first (glb_web=0xF, wdata 0x12345678, opsum_permit_pop=0x20 same cycle); ipsum ch2 served next with ipsum_permit_push=0x4.
3. ifmap_read_req=0xFFFFFFFF held -> grants ch0,1,2,…,31,0 in order, each with a single one-hot permit.
4. RD_LAT=3, ipsum ch31 read -> glb_en pulse, 2 idle WAIT cycles, permit on 4th cycle after latch; pointer wraps to 0.
5. Assert rst_n low during WAIT of an ifmap read -> all outputs 0 immediately, no permit; after release, the held request is re-granted from pointer 0.
